tx_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single parallel-to-serial `transmitter` among `NUM_REQ` parallel-domain requesters. It runs entirely in the `pclk` domain and sits directly in front of the transmitter's `tx_pdata_i` / `tx_pdata_valid_i` / `tx_pready_o` handshake. It locks the transmitter to one requester for a multi-word packet, bounded by `MAX_BURST` words and a `HOLD_TIMEOUT` stall guard.

---
 rtl/tx_req_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_tx_req_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_req_arbiter.sv
// Purpose: round-robin arbiter that locks the shared transmitter to one requester per packet.
// Latency: a requester word captured in IDLE is presented to the transmitter on the next pclk edge.
// Backpressure: with tx_pready_i low the word and valid are held, with no pop and no counter change.
module tx_req_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int HOLD_TIMEOUT = 32
) (
    input  logic                          pclk_i,
    input  logic                          prst_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_pdata_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          tx_pready_i,
    output logic [DATA_WIDTH-1:0]         tx_pdata_o,
    output logic                          tx_pdata_valid_o,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
    output logic                          busy_o,
    output logic                          timeout_o
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int HOLD_W  = $clog2(HOLD_TIMEOUT + 1);

    // Reject parameter sets the round-robin index arithmetic cannot handle.
    if (NUM_REQ < 2 || (NUM_REQ & (NUM_REQ - 1)) != 0) begin : g_bad_num_req
        $error("tx_req_arbiter: NUM_REQ must be a power of 2 and at least 2");
    end
    if (MAX_BURST < 1) begin : g_bad_max_burst
        $error("tx_req_arbiter: MAX_BURST must be at least 1");
    end
    if (HOLD_TIMEOUT < 1) begin : g_bad_hold_timeout
        $error("tx_req_arbiter: HOLD_TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [ID_W-1:0]         r_ptr;
    logic [ID_W-1:0]         r_grant;
    logic [BURST_W-1:0]      r_burst_cnt;
    logic [HOLD_W-1:0]       r_hold_cnt;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_last;
    logic                    r_timeout;

    logic                    w_rr_vld;
    logic [ID_W-1:0]         w_rr_idx;
    logic [ID_W-1:0]         w_cand;
    logic                    w_accept;
    logic                    w_burst_done;
    logic                    w_grant_vld;
    logic [HOLD_W-1:0]       w_hold_cnt_inc;
    logic                    w_cap;
    logic [ID_W-1:0]         w_cap_idx;
    logic [DATA_WIDTH-1:0]   w_cap_dat;
    logic                    w_cap_last;
    logic                    w_release;
    logic                    w_timeout_evt;

    assign w_accept       = (r_state == ST_SEND) && tx_pready_i;
    assign w_burst_done   = r_last || (r_burst_cnt == BURST_W'(MAX_BURST));
    assign w_grant_vld    = req_valid_i[r_grant];
    assign w_hold_cnt_inc = r_hold_cnt + HOLD_W'(1);
    assign w_cap_dat      = req_pdata_i[w_cap_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_cap_last     = req_last_i[w_cap_idx];

    // First valid requester searching ptr, ptr+1, ... (descending loop so the nearest wins).
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_idx = r_ptr;
        w_cand   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_cand = r_ptr + ID_W'(i);
            if (req_valid_i[w_cand]) begin
                w_rr_vld = 1'b1;
                w_rr_idx = w_cand;
            end
        end
    end

    // State register.
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, capture/release decisions and the one-hot pop strobe.
    always_comb begin
        w_state_nxt   = r_state;
        w_cap         = 1'b0;
        w_cap_idx     = r_grant;
        w_release     = 1'b0;
        w_timeout_evt = 1'b0;
        req_ready_o   = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_rr_vld) begin
                    w_cap       = 1'b1;
                    w_cap_idx   = w_rr_idx;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_accept) begin
                    if (w_burst_done) begin
                        w_release   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (w_grant_vld) begin
                        // Back-to-back: next word replaces the accepted one with no bubble.
                        w_cap       = 1'b1;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // A late word from the owner wins over the stall guard in the same cycle.
                if (w_grant_vld) begin
                    w_cap       = 1'b1;
                    w_state_nxt = ST_SEND;
                end else if (w_hold_cnt_inc == HOLD_W'(HOLD_TIMEOUT)) begin
                    w_release     = 1'b1;
                    w_timeout_evt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // No pop while reset is asserted: the in-flight word is simply dropped.
        if (w_cap && !prst_i) begin
            req_ready_o[w_cap_idx] = 1'b1;
        end
    end

    // Captured word, grant, round-robin pointer, burst/hold counters and timeout pulse.
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            r_data      <= '0;
            r_last      <= 1'b0;
            r_grant     <= '0;
            r_ptr       <= '0;
            r_burst_cnt <= '0;
            r_hold_cnt  <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= w_timeout_evt;

            if (w_cap) begin
                r_data  <= w_cap_dat;
                r_last  <= w_cap_last;
                r_grant <= w_cap_idx;
            end

            if (w_release) begin
                r_ptr       <= r_grant + ID_W'(1);
                r_burst_cnt <= '0;
            end else if (w_cap) begin
                if (r_state == ST_IDLE) begin
                    r_burst_cnt <= BURST_W'(1);
                end else begin
                    r_burst_cnt <= r_burst_cnt + BURST_W'(1);
                end
            end

            // Counts consecutive HOLD cycles; zero whenever HOLD is (re)entered.
            if (r_state == ST_HOLD && w_state_nxt == ST_HOLD) begin
                r_hold_cnt <= w_hold_cnt_inc;
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

    assign tx_pdata_o       = r_data;
    assign tx_pdata_valid_o = (r_state == ST_SEND);
    assign grant_id_o       = r_grant;
    assign busy_o           = (r_state != ST_IDLE);
    assign timeout_o        = r_timeout;

endmodule

// File: tb/tb_tx_req_arbiter.sv
// Purpose: self-checking bench for tx_req_arbiter with a per-accept scoreboard.
// Latency: stimulus is applied at the falling edge, outputs sampled 1 ns later.
// Backpressure: tx_pready_i is driven by the test sequence directly.
module tb_tx_req_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;
    localparam int HT = 8;

    logic              pclk_i = 1'b0;
    logic              prst_i;
    logic [NR*DW-1:0]  req_pdata_i;
    logic [NR-1:0]     req_valid_i;
    logic [NR-1:0]     req_last_i;
    logic [NR-1:0]     req_ready_o;
    logic              tx_pready_i;
    logic [DW-1:0]     tx_pdata_o;
    logic              tx_pdata_valid_o;
    logic [1:0]        grant_id_o;
    logic              busy_o;
    logic              timeout_o;

    always #5 pclk_i = ~pclk_i;

    tx_req_arbiter #(
        .DATA_WIDTH   (DW),
        .NUM_REQ      (NR),
        .MAX_BURST    (MB),
        .HOLD_TIMEOUT (HT)
    ) dut (
        .pclk_i           (pclk_i),
        .prst_i           (prst_i),
        .req_pdata_i      (req_pdata_i),
        .req_valid_i      (req_valid_i),
        .req_last_i       (req_last_i),
        .req_ready_o      (req_ready_o),
        .tx_pready_i      (tx_pready_i),
        .tx_pdata_o       (tx_pdata_o),
        .tx_pdata_valid_o (tx_pdata_valid_o),
        .grant_id_o       (grant_id_o),
        .busy_o           (busy_o),
        .timeout_o        (timeout_o)
    );

    typedef struct packed {
        logic [7:0] dat;
        logic       last;
    } word_t;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] dat;
    } exp_t;

    word_t       src_q [NR][$];
    exp_t        exp_q [$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          pop_cnt  = 0;
    int          p0;
    logic [NR-1:0] mon_ready;
    logic        mon_acc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_src(input int k, input logic [7:0] d, input logic l);
        word_t w;
        w.dat  = d;
        w.last = l;
        src_q[k].push_back(w);
    endtask

    task automatic push_exp(input int k, input logic [7:0] d);
        exp_t e;
        e.id  = 2'(k);
        e.dat = d;
        exp_q.push_back(e);
    endtask

    function automatic bit src_busy();
        bit b = 1'b0;
        for (int k = 0; k < NR; k++) begin
            if (src_q[k].size() > 0) b = 1'b1;
        end
        return b;
    endfunction

    // Present the head of each requester queue.
    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            if (src_q[k].size() > 0) begin
                req_valid_i[k]           = 1'b1;
                req_pdata_i[k*DW +: DW]  = src_q[k][0].dat;
                req_last_i[k]            = src_q[k][0].last;
            end else begin
                req_valid_i[k]           = 1'b0;
                req_pdata_i[k*DW +: DW]  = '0;
                req_last_i[k]            = 1'b0;
            end
        end
    endtask

    // One clock: drive, sample pops/accepts before the edge, then cross the edge.
    task automatic step();
        exp_t e;
        drive();
        #1;
        mon_ready = req_ready_o;
        mon_acc   = tx_pdata_valid_o && tx_pready_i;
        if (mon_ready != '0) check_val("pop_onehot", 32'($onehot(mon_ready)), 32'd1);
        for (int k = 0; k < NR; k++) begin
            if (mon_ready[k]) begin
                check_val("pop_valid", 32'(req_valid_i[k]), 32'd1);
                pop_cnt++;
                if (src_q[k].size() > 0) void'(src_q[k].pop_front());
            end
        end
        if (mon_acc) begin
            if (exp_q.size() == 0) begin
                check_val("acc_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_val("acc_id", 32'(grant_id_o), 32'(e.id));
                check_val("acc_dat", 32'(tx_pdata_o), 32'(e.dat));
            end
        end
        @(posedge pclk_i);
        @(negedge pclk_i);
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || src_busy() || busy_o) && n < budget) begin
            step();
            n++;
        end
        check_val("drain_exp", 32'(exp_q.size()), 32'd0);
        check_val("drain_busy", 32'(busy_o), 32'd0);
    endtask

    task automatic do_reset();
        prst_i = 1'b1;
        step();
        step();
        prst_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        prst_i      = 1'b1;
        tx_pready_i = 1'b0;
        req_pdata_i = '0;
        req_valid_i = '0;
        req_last_i  = '0;
        @(negedge pclk_i);
        do_reset();

        // Reset values
        check_val("rst_dat",   32'(tx_pdata_o), 32'd0);
        check_val("rst_vld",   32'(tx_pdata_valid_o), 32'd0);
        check_val("rst_ready", 32'(req_ready_o), 32'd0);
        check_val("rst_grant", 32'(grant_id_o), 32'd0);
        check_val("rst_busy",  32'(busy_o), 32'd0);
        check_val("rst_to",    32'(timeout_o), 32'd0);

        // Single word from requester 2
        tx_pready_i = 1'b1;
        push_src(2, 8'hA5, 1'b1);
        push_exp(2, 8'hA5);
        step();
        check_val("t1_pop", 32'(mon_ready), 32'b0100);
        check_val("t1_dat", 32'(tx_pdata_o), 32'hA5);
        check_val("t1_vld", 32'(tx_pdata_valid_o), 32'd1);
        check_val("t1_grant", 32'(grant_id_o), 32'd2);
        step();
        check_val("t1_acc", 32'(mon_acc), 32'd1);
        check_val("t1_nopop", 32'(mon_ready), 32'd0);
        check_val("t1_idle", 32'(busy_o), 32'd0);
        // Search now starts at 3: requester 3 beats requester 0
        push_src(0, 8'h0F, 1'b1);
        push_src(3, 8'h3F, 1'b1);
        push_exp(3, 8'h3F);
        push_exp(0, 8'h0F);
        run_until_idle(20);

        // Round robin from pointer 0 with one idle cycle between grants
        do_reset();
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < NR; k++) push_src(k, 8'(8'h40 + k*16 + j), 1'b1);
        end
        for (int i = 0; i < 2*NR; i++) push_exp(i % NR, 8'(8'h40 + (i % NR)*16 + i/NR));
        for (int i = 0; i < 2*NR; i++) begin
            step();
            check_val("rr_pop", 32'(mon_ready), 32'(1 << (i % NR)));
            check_val("rr_grant", 32'(grant_id_o), 32'(i % NR));
            step();
            check_val("rr_acc", 32'(mon_acc), 32'd1);
            check_val("rr_idle", 32'(busy_o), 32'd0);
        end

        // Backpressure: 5 cycles not ready, accept on the 6th
        tx_pready_i = 1'b0;
        p0 = pop_cnt;
        push_src(1, 8'h3C, 1'b1);
        push_exp(1, 8'h3C);
        step();
        check_val("bp_pop", 32'(mon_ready), 32'b0010);
        for (int c = 0; c < 5; c++) begin
            check_val("bp_dat", 32'(tx_pdata_o), 32'h3C);
            check_val("bp_vld", 32'(tx_pdata_valid_o), 32'd1);
            step();
            check_val("bp_noacc", 32'(mon_acc), 32'd0);
        end
        tx_pready_i = 1'b1;
        check_val("bp_dat6", 32'(tx_pdata_o), 32'h3C);
        step();
        check_val("bp_acc", 32'(mon_acc), 32'd1);
        check_val("bp_pops", 32'(pop_cnt - p0), 32'd1);

        // Packet lock: requester 1 keeps the grant while requester 0 waits
        push_src(1, 8'h11, 1'b0);
        push_src(1, 8'h22, 1'b0);
        push_src(1, 8'h33, 1'b1);
        push_exp(1, 8'h11);
        push_exp(1, 8'h22);
        push_exp(1, 8'h33);
        push_exp(0, 8'h55);
        step();
        check_val("pl_pop0", 32'(mon_ready), 32'b0010);
        push_src(0, 8'h55, 1'b1);
        for (int c = 0; c < 2; c++) begin
            step();
            check_val("pl_acc", 32'(mon_acc), 32'd1);
            check_val("pl_pop", 32'(mon_ready), 32'b0010);
        end
        step();
        check_val("pl_acc_last", 32'(mon_acc), 32'd1);
        check_val("pl_nopop", 32'(mon_ready), 32'd0);
        check_val("pl_idle", 32'(busy_o), 32'd0);
        step();
        check_val("pl_next", 32'(mon_ready), 32'b0001);
        step();
        check_val("pl_acc0", 32'(mon_acc), 32'd1);

        // Burst cap of 4, requester 1 interleaves, requester 0 resumes then stalls out
        for (int i = 0; i < 6; i++) push_src(0, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 4; i++) push_exp(0, 8'(8'h60 + i));
        push_exp(1, 8'h70);
        push_exp(0, 8'h64);
        push_exp(0, 8'h65);
        step();
        push_src(1, 8'h70, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step();
            check_val("bc_pop", 32'(mon_ready), 32'b0001);
        end
        step();
        check_val("bc_acc4", 32'(mon_acc), 32'd1);
        check_val("bc_nopop", 32'(mon_ready), 32'd0);
        check_val("bc_release", 32'(busy_o), 32'd0);
        step();
        check_val("bc_next", 32'(mon_ready), 32'b0010);
        step();
        step();
        check_val("bc_resume", 32'(mon_ready), 32'b0001);
        run_until_idle(40);
        check_val("bc_timeout", 32'(timeout_o), 32'd1);

        // Stall: HOLD abandoned after HT cycles, others ignored meanwhile
        push_src(3, 8'h3D, 1'b0);
        push_exp(3, 8'h3D);
        step();
        check_val("st_pop", 32'(mon_ready), 32'b1000);
        step();
        check_val("st_hold_busy", 32'(busy_o), 32'd1);
        check_val("st_hold_vld", 32'(tx_pdata_valid_o), 32'd0);
        push_src(0, 8'h77, 1'b1);
        push_exp(0, 8'h77);
        for (int c = 1; c < HT; c++) begin
            step();
            check_val("st_hold_nopop", 32'(mon_ready), 32'd0);
            check_val("st_no_to", 32'(timeout_o), 32'd0);
            check_val("st_still_busy", 32'(busy_o), 32'd1);
        end
        step();
        check_val("st_to_pulse", 32'(timeout_o), 32'd1);
        check_val("st_to_idle", 32'(busy_o), 32'd0);
        step();
        check_val("st_to_end", 32'(timeout_o), 32'd0);
        check_val("st_after_pop", 32'(mon_ready), 32'b0001);
        run_until_idle(20);

        // Reset asserted during SEND
        tx_pready_i = 1'b0;
        push_src(2, 8'h99, 1'b0);
        step();
        check_val("rs_pop", 32'(mon_ready), 32'b0100);
        check_val("rs_vld", 32'(tx_pdata_valid_o), 32'd1);
        prst_i = 1'b1;
        step();
        check_val("rs_nopop", 32'(mon_ready), 32'd0);
        check_val("rs_dat",   32'(tx_pdata_o), 32'd0);
        check_val("rs_vld0",  32'(tx_pdata_valid_o), 32'd0);
        check_val("rs_grant", 32'(grant_id_o), 32'd0);
        check_val("rs_busy",  32'(busy_o), 32'd0);
        check_val("rs_to",    32'(timeout_o), 32'd0);
        check_val("rs_ready", 32'(req_ready_o), 32'd0);
        prst_i      = 1'b0;
        tx_pready_i = 1'b1;
        // Pointer back at 0: requester 1 before requester 3
        push_src(3, 8'hAB, 1'b1);
        push_src(1, 8'hCD, 1'b1);
        push_exp(1, 8'hCD);
        push_exp(3, 8'hAB);
        run_until_idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
